dsp_mac_seq: RTL and testbench

DSP_MAC_SEQ -- requirements
Module: dsp_mac_seq

---
 rtl/dsp_mac_seq.sv | 190 +++++++++++++++++++
 tb/tb_dsp_mac_seq.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : dsp_mac_seq
//  Description : Dot-product sequencer driving a DSP48A1 slice configured as
//                a multiply-accumulator (A1REG=B1REG=MREG=PREG=1).
//                A transaction flushes the slice, streams len A/B pairs into
//                it, waits for the pipeline to drain and captures P.
//  Revision    : 1.0 - initial release
// ============================================================================
module dsp_mac_seq #(
  parameter int LEN_W    = 8,
  parameter int PIPE_LAT = 3
) (
  input  logic             CLK,
  input  logic             RST,

  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,

  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,

  output logic [17:0]      dsp_A,
  output logic [17:0]      dsp_B,
  output logic [7:0]       dsp_OPMODE,
  output logic             dsp_CE,
  output logic             dsp_RSTM,
  output logic             dsp_RSTP,
  input  logic [47:0]      dsp_P,

  output logic [47:0]      result,
  output logic             done
);

  // X = M, Z = P, pre-adder bypassed, post-adder adds, CARRYIN = 0.
  localparam logic [7:0] OPMODE_MAC  = 8'h09;
  localparam logic [7:0] OPMODE_IDLE = 8'h00;

  // Wait counter for the CLEAR and DRAIN phases counts 0 .. PIPE_LAT-1.
  localparam int              WAIT_W    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(PIPE_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ACCUM = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q;
  logic [LEN_W:0]    cnt_q;      // one extra bit so len = 2^LEN_W-1 never wraps
  logic [LEN_W:0]    cnt_d;
  logic [LEN_W-1:0]  len_q;
  logic [WAIT_W-1:0] wait_q;
  logic [47:0]       result_q;
  logic              done_q;
  logic              in_ready_q;
  logic              busy_q;
  logic              ce_q;
  logic [7:0]        opmode_q;
  logic              rst_mp_q;   // shared by RSTM and RSTP
  logic              accept_w;

  // A pair is taken when the source offers one while the sequencer is ready.
  always_comb begin
    accept_w = in_valid & in_ready_q;
    cnt_d    = cnt_q + {{LEN_W{1'b0}}, accept_w};
  end

  // Operands reach the slice in the acceptance cycle; otherwise feed zeros so
  // M becomes zero and P simply holds its running sum.
  always_comb begin
    dsp_A = '0;
    dsp_B = '0;
    if (accept_w) begin
      dsp_A = in_a;
      dsp_B = in_b;
    end
  end

  // Sequencer FSM; all state-derived outputs are registered alongside state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      wait_q     <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      ce_q       <= 1'b0;
      opmode_q   <= OPMODE_IDLE;
      rst_mp_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            len_q    <= len;
            cnt_q    <= '0;
            wait_q   <= '0;
            busy_q   <= 1'b1;
            ce_q     <= 1'b1;
            opmode_q <= OPMODE_MAC;
            rst_mp_q <= 1'b1;
            state_q  <= S_CLEAR;
          end
        end

        // Hold RSTM/RSTP with zero operands long enough to flush every
        // pipeline stage, including anything left by an aborted transaction.
        S_CLEAR: begin
          if (wait_q == LAST_WAIT) begin
            wait_q   <= '0;
            rst_mp_q <= 1'b0;
            if (len_q == '0) begin
              state_q <= S_DRAIN;
            end else begin
              in_ready_q <= 1'b1;
              state_q    <= S_ACCUM;
            end
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end

        // Ready drops in the same edge that takes the final pair, so exactly
        // len pairs are ever accepted.
        S_ACCUM: begin
          cnt_q <= cnt_d;
          if (cnt_d == {1'b0, len_q}) begin
            in_ready_q <= 1'b0;
            state_q    <= S_DRAIN;
          end
        end

        // The last product needs PIPE_LAT cycles to land in P; capture it on
        // the final drain cycle.
        S_DRAIN: begin
          if (wait_q == LAST_WAIT) begin
            wait_q   <= '0;
            result_q <= dsp_P;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end

        S_DONE: begin
          done_q   <= 1'b0;
          busy_q   <= 1'b0;
          ce_q     <= 1'b0;
          opmode_q <= OPMODE_IDLE;
          state_q  <= S_IDLE;
        end

        default: begin
          state_q    <= S_IDLE;
          done_q     <= 1'b0;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          ce_q       <= 1'b0;
          opmode_q   <= OPMODE_IDLE;
          rst_mp_q   <= 1'b0;
        end
      endcase
    end
  end

  // Output mapping from the registered state.
  always_comb begin
    busy       = busy_q;
    in_ready   = in_ready_q;
    dsp_OPMODE = opmode_q;
    dsp_CE     = ce_q;
    dsp_RSTM   = rst_mp_q;
    dsp_RSTP   = rst_mp_q;
    result     = result_q;
    done       = done_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_dsp_mac_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_dsp_mac_seq
//  Description : Bench for dsp_mac_seq with a behavioural DSP48A1 MAC slice
//                and a dot-product reference computed with plain arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dsp_mac_seq;

  localparam int LEN_W    = 8;
  localparam int PIPE_LAT = 3;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             busy;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [17:0]      in_a = '0;
  logic [17:0]      in_b = '0;
  logic [17:0]      dsp_A, dsp_B;
  logic [7:0]       dsp_OPMODE;
  logic             dsp_CE, dsp_RSTM, dsp_RSTP;
  logic [47:0]      dsp_P;
  logic [47:0]      result;
  logic             done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic signed [17:0] a_arr [256];
  logic signed [17:0] b_arr [256];

  dsp_mac_seq #(.LEN_W(LEN_W), .PIPE_LAT(PIPE_LAT)) dut (
    .CLK(CLK), .RST(RST), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .dsp_A(dsp_A), .dsp_B(dsp_B), .dsp_OPMODE(dsp_OPMODE), .dsp_CE(dsp_CE),
    .dsp_RSTM(dsp_RSTM), .dsp_RSTP(dsp_RSTP), .dsp_P(dsp_P),
    .result(result), .done(done)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural DSP48A1 slice: A1/B1, M and P registers, registered OPMODE.
  // Registers start with junk so only the sequencer's flush can zero them.
  logic signed [17:0] s_a1 = 18'h15A5A;
  logic signed [17:0] s_b1 = 18'h0A5A5;
  logic signed [35:0] s_m  = 36'h9_8765_4321;
  logic        [7:0]  s_op = 8'h09;
  logic        [47:0] s_p  = 48'hDEAD_BEEF_1234;
  logic        [47:0] s_x, s_z;

  always_comb begin
    case (s_op[1:0])
      2'b01:   s_x = {{12{s_m[35]}}, s_m};
      2'b10:   s_x = s_p;
      default: s_x = '0;
    endcase
    case (s_op[3:2])
      2'b10:   s_z = s_p;
      default: s_z = '0;
    endcase
  end

  always @(posedge CLK) begin
    if (dsp_CE) begin
      s_a1 <= dsp_A;
      s_b1 <= dsp_B;
      s_op <= dsp_OPMODE;
    end
    if (dsp_RSTM)    s_m <= '0;
    else if (dsp_CE) s_m <= s_a1 * s_b1;
    if (dsp_RSTP)    s_p <= '0;
    else if (dsp_CE) s_p <= s_op[7] ? (s_z - s_x) : (s_z + s_x);
  end
  assign dsp_P = s_p;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // Reference: signed dot product of the first n pairs, wrapped to 48 bits.
  function automatic logic [47:0] ref_dot(input int n);
    longint acc = 0;
    for (int i = 0; i < n; i++)
      acc += longint'(a_arr[i]) * longint'(b_arr[i]);
    return acc[47:0];
  endfunction

  // Runs one transaction; gap < 0 means random bubble count per pair.
  task automatic drive_txn(input int n, input int gap,
                           output logic [47:0] res, output logic [47:0] res_hold,
                           output int lat, output int n_acc, output int n_done,
                           output int ready_bad, output int dsp_bad,
                           output int idle_bad, output bit tmo);
    int idx, gcnt, s, k, dcyc, budget, after;
    bit seen;
    idx = 0; gcnt = 0; n_acc = 0; n_done = 0; ready_bad = 0; dsp_bad = 0;
    idle_bad = 0; seen = 0; res = '0; res_hold = '0; lat = -1; after = 0;
    k = 0; dcyc = 0;
    budget = n * 4 + 4 * PIPE_LAT + 20;
    @(posedge CLK); #1;
    start = 1'b1; len = n[LEN_W-1:0]; s = cyc;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int c = 0; c < budget && after < 4; c++) begin
      if (idx < n && gcnt == 0) begin
        in_valid = 1'b1; in_a = a_arr[idx]; in_b = b_arr[idx];
      end else begin
        in_valid = 1'b0; in_a = 18'($urandom); in_b = 18'($urandom);
      end
      #1;
      if (in_ready && (idx >= n || cyc <= s + PIPE_LAT)) ready_bad++;
      if (in_valid && in_ready) begin
        if (dsp_A !== in_a || dsp_B !== in_b) dsp_bad++;
        idx++; n_acc++; k = cyc;
        gcnt = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      end else begin
        if (dsp_A !== 18'd0 || dsp_B !== 18'd0) dsp_bad++;
        if (!in_valid && gcnt > 0) gcnt--;
      end
      if (done) begin
        n_done++;
        if (!seen) begin res = result; dcyc = cyc; seen = 1; end
      end
      if (seen) after++;
      if (after >= 3 && (busy || dsp_CE || in_ready || dsp_OPMODE !== 8'h00)) idle_bad++;
      if (after == 3) res_hold = result;
      @(posedge CLK); #1;
    end
    in_valid = 1'b0;
    tmo = !seen;
    if (seen) lat = (n > 0) ? (dcyc - k) : (dcyc - s);
  endtask

  task automatic test_reset;
    #1;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 || result !== 48'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy=%b in_ready=%b done=%b result=%h required 0 0 0 0",
               busy, in_ready, done, result);
    end
    n_checks++;
    if (dsp_CE !== 1'b0 || dsp_OPMODE !== 8'h00 || dsp_A !== 18'd0 || dsp_B !== 18'd0 ||
        dsp_RSTM !== 1'b0 || dsp_RSTP !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_dsp: CE=%b OPMODE=%h A=%h B=%h RSTM=%b RSTP=%b required all 0",
               dsp_CE, dsp_OPMODE, dsp_A, dsp_B, dsp_RSTM, dsp_RSTP);
    end
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(posedge CLK); #1;
    n_checks++;
    if (busy !== 1'b0 || dsp_CE !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: busy=%b CE=%b required 0 0", busy, dsp_CE);
    end
  endtask

  task automatic test_basic;
    logic [47:0] r, rh; int lat, na, nd, rb, db, ib; bit tmo;
    a_arr[0] = 2; b_arr[0] = 3; a_arr[1] = 4; b_arr[1] = 5; a_arr[2] = 6; b_arr[2] = 7;
    drive_txn(3, 0, r, rh, lat, na, nd, rb, db, ib, tmo);
    n_checks++;
    if (tmo || r !== 48'h44) begin
      n_fail++; $display("FAIL basic_result: got %h (timeout=%b) required %h", r, tmo, 48'h44);
    end
    n_checks++;
    if (nd != 1 || lat != PIPE_LAT + 1) begin
      n_fail++; $display("FAIL basic_done: pulses=%0d latency=%0d required 1 and %0d", nd, lat, PIPE_LAT + 1);
    end
    n_checks++;
    if (na != 3 || rb != 0 || db != 0 || ib != 0) begin
      n_fail++; $display("FAIL basic_handshake: accepted=%0d ready_bad=%0d dsp_bad=%0d idle_bad=%0d required 3 0 0 0", na, rb, db, ib);
    end
    n_checks++;
    if (rh !== 48'h44) begin
      n_fail++; $display("FAIL basic_hold: got %h required %h", rh, 48'h44);
    end
  endtask

  task automatic test_negative;
    logic [47:0] r, rh; int lat, na, nd, rb, db, ib; bit tmo;
    a_arr[0] = 18'sh3FFFE; b_arr[0] = 5;
    drive_txn(1, 0, r, rh, lat, na, nd, rb, db, ib, tmo);
    n_checks++;
    if (tmo || r !== 48'hFFFF_FFFF_FFF6 || nd != 1 || lat != PIPE_LAT + 1) begin
      n_fail++; $display("FAIL negative: got %h pulses=%0d lat=%0d required %h 1 %0d",
                         r, nd, lat, 48'hFFFF_FFFF_FFF6, PIPE_LAT + 1);
    end
  endtask

  task automatic test_bubbles;
    logic [47:0] r, rh; int lat, na, nd, rb, db, ib; bit tmo;
    a_arr[0] = 2; b_arr[0] = 3; a_arr[1] = 4; b_arr[1] = 5; a_arr[2] = 6; b_arr[2] = 7;
    drive_txn(3, 2, r, rh, lat, na, nd, rb, db, ib, tmo);
    n_checks++;
    if (tmo || r !== 48'd68 || nd != 1) begin
      n_fail++; $display("FAIL bubbles_result: got %h pulses=%0d required %h 1", r, nd, 48'd68);
    end
    n_checks++;
    if (rb != 0 || db != 0 || na != 3 || lat != PIPE_LAT + 1) begin
      n_fail++; $display("FAIL bubbles_ready: ready_bad=%0d dsp_bad=%0d accepted=%0d lat=%0d required 0 0 3 %0d",
                         rb, db, na, lat, PIPE_LAT + 1);
    end
  endtask

  task automatic test_len_zero;
    logic [47:0] r, rh; int lat, na, nd, rb, db, ib; bit tmo;
    for (int i = 0; i < 4; i++) begin a_arr[i] = 18'($urandom); b_arr[i] = 18'($urandom); end
    drive_txn(0, 0, r, rh, lat, na, nd, rb, db, ib, tmo);
    n_checks++;
    if (tmo || r !== 48'd0 || nd != 1) begin
      n_fail++; $display("FAIL len0_result: got %h pulses=%0d required 0 1", r, nd);
    end
    n_checks++;
    if (lat != 2 * PIPE_LAT + 1 || na != 0 || rb != 0) begin
      n_fail++; $display("FAIL len0_timing: lat=%0d accepted=%0d ready_bad=%0d required %0d 0 0",
                         lat, na, rb, 2 * PIPE_LAT + 1);
    end
  endtask

  task automatic test_abort;
    logic [47:0] r, rh; int lat, na, nd, rb, db, ib, got, dones; bit tmo;
    a_arr[0] = 2; b_arr[0] = 3; a_arr[1] = 4; b_arr[1] = 5; a_arr[2] = 6; b_arr[2] = 7;
    got = 0; dones = 0;
    @(posedge CLK); #1;
    start = 1'b1; len = 8'd3;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int c = 0; c < 30 && got < 2; c++) begin
      in_valid = 1'b1; in_a = a_arr[got]; in_b = b_arr[got];
      #1;
      if (in_ready) got++;
      @(posedge CLK); #1;
    end
    in_valid = 1'b0;
    RST = 1'b1;
    #1;
    n_checks++;
    if (got != 2 || busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 || result !== 48'd0) begin
      n_fail++; $display("FAIL abort_ctrl: got=%0d busy=%b in_ready=%b done=%b result=%h required 2 0 0 0 0",
                         got, busy, in_ready, done, result);
    end
    n_checks++;
    if (dsp_CE !== 1'b0 || dsp_OPMODE !== 8'h00 || dsp_RSTM !== 1'b0 || dsp_RSTP !== 1'b0 ||
        dsp_A !== 18'd0 || dsp_B !== 18'd0) begin
      n_fail++; $display("FAIL abort_dsp: CE=%b OPMODE=%h RSTM=%b RSTP=%b A=%h B=%h required all 0",
                         dsp_CE, dsp_OPMODE, dsp_RSTM, dsp_RSTP, dsp_A, dsp_B);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge CLK); #1;
      if (done || busy) dones++;
    end
    n_checks++;
    if (dones != 0) begin
      n_fail++; $display("FAIL abort_no_done: done/busy cycles=%0d required 0", dones);
    end
    a_arr[0] = 3; b_arr[0] = 3;
    drive_txn(1, 0, r, rh, lat, na, nd, rb, db, ib, tmo);
    n_checks++;
    if (tmo || r !== 48'd9 || nd != 1) begin
      n_fail++; $display("FAIL abort_recover: got %h pulses=%0d required %h 1", r, nd, 48'd9);
    end
  endtask

  task automatic test_back_to_back;
    logic [47:0] r, rh; int lat, na, nd, rb, db, ib; bit tmo;
    a_arr[0] = 1; b_arr[0] = 1; a_arr[1] = 1; b_arr[1] = 1;
    drive_txn(2, 0, r, rh, lat, na, nd, rb, db, ib, tmo);
    n_checks++;
    if (tmo || r !== 48'd2) begin
      n_fail++; $display("FAIL b2b_first: got %h required %h", r, 48'd2);
    end
    a_arr[0] = 10; b_arr[0] = 10;
    drive_txn(1, 0, r, rh, lat, na, nd, rb, db, ib, tmo);
    n_checks++;
    if (tmo || r !== 48'd100 || nd != 1) begin
      n_fail++; $display("FAIL b2b_second: got %h pulses=%0d required %h 1", r, nd, 48'd100);
    end
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 3))
        0:       a_arr[i] = 18'sh20000;
        1:       a_arr[i] = 18'sh1FFFF;
        default: a_arr[i] = 18'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0:       b_arr[i] = 18'sh20000;
        1:       b_arr[i] = 18'sh3FFFF;
        default: b_arr[i] = 18'($urandom);
      endcase
    end
  endtask

  task automatic test_random;
    logic [47:0] r, rh, exp; int lat, na, nd, rb, db, ib, n; bit tmo;
    for (int t = 0; t < 8; t++) begin
      n = int'($urandom_range(1, 20));
      fill_random(n);
      exp = ref_dot(n);
      drive_txn(n, -1, r, rh, lat, na, nd, rb, db, ib, tmo);
      n_checks++;
      if (tmo || r !== exp || nd != 1 || na != n || lat != PIPE_LAT + 1 || rb != 0 || db != 0) begin
        n_fail++;
        $display("FAIL random_%0d: len=%0d got %h pulses=%0d acc=%0d lat=%0d rb=%0d db=%0d required %h 1 %0d %0d 0 0",
                 t, n, r, nd, na, lat, rb, db, exp, n, PIPE_LAT + 1);
      end
    end
  endtask

  task automatic test_max_len;
    logic [47:0] r, rh, exp; int lat, na, nd, rb, db, ib, n; bit tmo;
    n = (1 << LEN_W) - 1;
    fill_random(n);
    exp = ref_dot(n);
    drive_txn(n, 0, r, rh, lat, na, nd, rb, db, ib, tmo);
    n_checks++;
    if (tmo || r !== exp || na != n || nd != 1 || rb != 0) begin
      n_fail++; $display("FAIL max_len: got %h acc=%0d pulses=%0d rb=%0d required %h %0d 1 0",
                         r, na, nd, rb, exp, n);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_bubbles();
    test_len_zero();
    test_abort();
    test_back_to_back();
    test_random();
    test_max_len();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
